// File: rtl/mfsk_nco_mod.sv
// M-ary FSK modulator: serialises DATA_W-bit words into SYM_BITS-wide symbols, each keying a phase-continuous NCO tone.
// Latency: the first symbol's tone appears the cycle after the handshake; phase_out lags the accumulator by one en cycle.
// Backpressure: in_ready is high in IDLE and in the final cycle of the last symbol; en=0 freezes everything and drops in_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   en              clock enable for accumulator, counters and handshake
//   in_data/in_valid/in_ready   word input handshake
//   phase_out       registered top OUT_W bits of the phase accumulator
//   tone_out        current tone index (M-1 = mark while idle)
//   sym_strobe      pulse on first cycle of each data symbol
//   busy            high while a word is on air
//   underrun        pulse when the last symbol ends with no follow-on word
module mfsk_nco_mod #(
    parameter int DATA_W    = 8,
    parameter int SYM_BITS  = 1,
    parameter int PHASE_W   = 24,
    parameter int OUT_W     = 12,
    parameter int SYM_CYC   = 50000,
    parameter int FTW_BASE  = 8389,
    parameter int FTW_STEP  = 8389,
    parameter int MSB_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [OUT_W-1:0]    phase_out,
    output logic [SYM_BITS-1:0] tone_out,
    output logic                sym_strobe,
    output logic                busy,
    output logic                underrun
);

    localparam int NSYM  = DATA_W / SYM_BITS;
    localparam int CNT_W = $clog2(SYM_CYC);
    localparam int SL_W  = $clog2(NSYM + 1);

    localparam logic [PHASE_W-1:0]  BASE_W = PHASE_W'(FTW_BASE);
    localparam logic [PHASE_W-1:0]  STEP_W = PHASE_W'(FTW_STEP);
    localparam logic [SYM_BITS-1:0] MARK   = '1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [DATA_W-1:0]   shreg_nxt;
    logic [SL_W-1:0]     sym_left;
    logic [CNT_W-1:0]    cnt;
    logic [PHASE_W-1:0]  phase;
    logic                rdy_done;
    logic                last_cyc;
    logic                last_sym;
    logic                hs;

    // Tuning word wraps modulo 2^PHASE_W through the PHASE_W-bit arithmetic.
    function automatic logic [PHASE_W-1:0] ftw(input logic [SYM_BITS-1:0] s);
        return BASE_W + STEP_W * PHASE_W'(s);
    endfunction

    function automatic logic [SYM_BITS-1:0] first_sym(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0)
            return w[DATA_W-1 -: SYM_BITS];
        else
            return w[SYM_BITS-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0)
            return w << SYM_BITS;
        else
            return w >> SYM_BITS;
    endfunction

    always_comb begin
        last_cyc  = (cnt == CNT_W'(SYM_CYC - 1));
        last_sym  = (sym_left == SL_W'(1));
        shreg_nxt = shift_word(shreg);
        // rdy_done holds in_ready low for the first cycle out of reset.
        in_ready  = en & rdy_done & ((state == IDLE) | (last_cyc & last_sym));
        hs        = in_valid & in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            sym_left   <= '0;
            cnt        <= '0;
            phase      <= '0;
            phase_out  <= '0;
            tone_out   <= MARK;
            sym_strobe <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
            rdy_done   <= 1'b0;
        end else begin
            sym_strobe <= 1'b0;
            underrun   <= 1'b0;
            rdy_done   <= 1'b1;
            if (en) begin
                // Accumulator is never cleared on tone change, keeping phase continuous.
                phase     <= phase + ftw(tone_out);
                phase_out <= phase[PHASE_W-1 -: OUT_W];
                if (hs) begin
                    // Covers both a fresh start from IDLE and a gapless follow-on word.
                    state      <= SEND;
                    shreg      <= in_data;
                    sym_left   <= SL_W'(NSYM);
                    cnt        <= '0;
                    tone_out   <= first_sym(in_data);
                    sym_strobe <= 1'b1;
                    busy       <= 1'b1;
                end else if (state == SEND) begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (last_sym) begin
                            state    <= IDLE;
                            tone_out <= MARK;
                            busy     <= 1'b0;
                            underrun <= 1'b1;
                        end else begin
                            sym_left   <= sym_left - SL_W'(1);
                            shreg      <= shreg_nxt;
                            tone_out   <= first_sym(shreg_nxt);
                            sym_strobe <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mfsk_nco_mod.sv
`timescale 1ns/1ps
module tb_mfsk_nco_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, en;

    // A: binary FSK, 4-cycle symbols, default 24-bit NCO
    logic [7:0]  a_in_data;
    logic        a_in_valid, a_in_ready, a_sym_strobe, a_busy, a_underrun;
    logic [11:0] a_phase_out;
    logic [0:0]  a_tone_out;

    // B: 4-FSK, LSB first, 16-bit NCO, FTW(s) = 0x100 + s*0x100
    logic [7:0]  b_in_data;
    logic        b_in_valid, b_in_ready, b_sym_strobe, b_busy, b_underrun;
    logic [15:0] b_phase_out;
    logic [1:0]  b_tone_out;

    // C: 8-bit NCO with FTW 0x60 on every tone, for wrap checks
    logic [7:0]  c_in_data;
    logic        c_in_valid, c_in_ready, c_sym_strobe, c_busy, c_underrun;
    logic [7:0]  c_phase_out;
    logic [0:0]  c_tone_out;

    mfsk_nco_mod #(.DATA_W(8), .SYM_BITS(1), .PHASE_W(24), .OUT_W(12), .SYM_CYC(4),
                   .FTW_BASE(8389), .FTW_STEP(8389), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .phase_out(a_phase_out), .tone_out(a_tone_out),
        .sym_strobe(a_sym_strobe), .busy(a_busy), .underrun(a_underrun));

    mfsk_nco_mod #(.DATA_W(8), .SYM_BITS(2), .PHASE_W(16), .OUT_W(16), .SYM_CYC(4),
                   .FTW_BASE(256), .FTW_STEP(256), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .phase_out(b_phase_out), .tone_out(b_tone_out),
        .sym_strobe(b_sym_strobe), .busy(b_busy), .underrun(b_underrun));

    mfsk_nco_mod #(.DATA_W(8), .SYM_BITS(1), .PHASE_W(8), .OUT_W(8), .SYM_CYC(4),
                   .FTW_BASE(96), .FTW_STEP(0), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .phase_out(c_phase_out), .tone_out(c_tone_out),
        .sym_strobe(c_sym_strobe), .busy(c_busy), .underrun(c_underrun));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        en  = 1'b1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        c_in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Checks A cycle by cycle from the first symbol; bits holds expected tones, first symbol at bit nsym-1.
    task automatic a_stream(input logic [15:0] bits, input int nsym);
        int strobes;
        strobes = 0;
        for (int k = 0; k < nsym * 4; k++) begin
            chk("a_tone", 32'(a_tone_out), 32'(bits[nsym - 1 - k / 4]));
            chk("a_strobe", 32'(a_sym_strobe), 32'((k % 4) == 0));
            chk("a_busy", 32'(a_busy), 32'd1);
            chk("a_ready", 32'(a_in_ready), 32'((k % 32) == 31));
            chk("a_underrun", 32'(a_underrun), 32'd0);
            if (a_sym_strobe) strobes++;
            if (k >= 32) a_in_valid = 1'b0;
            tick;
        end
        chk("a_strobe_count", 32'(strobes), 32'(nsym));
        chk("a_end_underrun", 32'(a_underrun), 32'd1);
        chk("a_end_busy", 32'(a_busy), 32'd0);
        chk("a_end_tone", 32'(a_tone_out), 32'd1);
        chk("a_end_ready", 32'(a_in_ready), 32'd1);
        tick;
        chk("a_underrun_1cyc", 32'(a_underrun), 32'd0);
    endtask

    logic [7:0]  wrap_exp [4];
    logic [15:0] b_ph, b_po;
    int          b_et;

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        a_in_data = 8'h00; b_in_data = 8'h00; c_in_data = 8'h00;
        a_in_valid = 1'b0; b_in_valid = 1'b0; c_in_valid = 1'b0;
        wrap_exp[0] = 8'h00; wrap_exp[1] = 8'h60; wrap_exp[2] = 8'hC0; wrap_exp[3] = 8'h20;

        // Reset state
        tick;
        tick;
        chk("rst_a_phase", 32'(a_phase_out), 32'd0);
        chk("rst_a_tone", 32'(a_tone_out), 32'd1);
        chk("rst_b_tone", 32'(b_tone_out), 32'd3);
        chk("rst_a_busy", 32'(a_busy), 32'd0);
        chk("rst_a_ready", 32'(a_in_ready), 32'd0);
        chk("rst_a_strobe", 32'(a_sym_strobe), 32'd0);
        chk("rst_a_underrun", 32'(a_underrun), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready_low", 32'(a_in_ready), 32'd0);
        chk("c_phase_init", 32'(c_phase_out), 32'd0);

        // Phase wrap on 8-bit accumulator
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("c_phase_wrap", 32'(c_phase_out), 32'(wrap_exp[i]));
            if (i == 0) chk("post_rst_ready_high", 32'(a_in_ready), 32'd1);
        end

        // Single word 0xA5, MSB first
        do_reset;
        tick;
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        a_in_data  = 8'h00;
        a_stream(16'h00A5, 8);

        // Back-to-back 0xFF then 0x00 with in_valid held
        do_reset;
        tick;
        a_in_data  = 8'hFF;
        a_in_valid = 1'b1;
        tick;
        a_in_data  = 8'h00;
        a_stream(16'hFF00, 16);

        // 4-FSK, LSB first, 0x1B -> tones 3,2,1,0 with continuous phase
        do_reset;
        tick;
        b_in_data  = 8'h1B;
        b_in_valid = 1'b1;
        tick;
        b_in_valid = 1'b0;
        b_ph = 16'h0800;
        b_po = 16'h0400;
        for (int k = 0; k < 20; k++) begin
            b_et = (k < 16) ? (3 - k / 4) : 3;
            chk("b_tone", 32'(b_tone_out), 32'(b_et));
            chk("b_phase", 32'(b_phase_out), 32'(b_po));
            if (k == 16) chk("b_underrun", 32'(b_underrun), 32'd1);
            b_po = b_ph;
            b_ph = b_ph + 16'((b_et + 1) * 256);
            tick;
        end

        // en gates the handshake, then freeze mid-symbol for 10 cycles
        do_reset;
        tick;
        en = 1'b0;
        a_in_data  = 8'hA5;
        a_in_valid = 1'b1;
        #1;
        chk("en_gates_ready", 32'(a_in_ready), 32'd0);
        tick;
        chk("en_gates_hs", 32'(a_busy), 32'd0);
        en = 1'b1;
        tick;
        a_in_valid = 1'b0;
        chk("en_hs_busy", 32'(a_busy), 32'd1);
        tick;
        tick;
        chk("en_pre_phase", 32'(a_phase_out), 32'd12);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("frz_phase", 32'(a_phase_out), 32'd12);
            chk("frz_tone", 32'(a_tone_out), 32'd1);
            chk("frz_strobe", 32'(a_sym_strobe), 32'd0);
            chk("frz_ready", 32'(a_in_ready), 32'd0);
        end
        en = 1'b1;
        tick;
        chk("resume_tone", 32'(a_tone_out), 32'd1);
        chk("resume_phase", 32'(a_phase_out), 32'd16);
        tick;
        chk("resume_next_tone", 32'(a_tone_out), 32'd0);
        chk("resume_strobe", 32'(a_sym_strobe), 32'd1);
        chk("resume_phase2", 32'(a_phase_out), 32'd20);

        // Reset in the middle of a word
        do_reset;
        tick;
        a_in_data  = 8'h00;
        a_in_valid = 1'b1;
        tick;
        a_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("mid_tone_before", 32'(a_tone_out), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_phase", 32'(a_phase_out), 32'd0);
        chk("mid_rst_tone", 32'(a_tone_out), 32'd1);
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_underrun", 32'(a_underrun), 32'd0);
        tick;
        rst = 1'b0;
        tick;
        chk("mid_after_underrun", 32'(a_underrun), 32'd0);
        chk("mid_after_busy", 32'(a_busy), 32'd0);
        chk("mid_after_tone", 32'(a_tone_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
